risc_sequencer: RTL and testbench

//  Parametrised CPU control sequencer: owns the 8-phase instruction counter and decodes per-phase

---
 rtl/risc_sequencer.sv | 105 ++++++++++
 tb/tb_risc_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/risc_sequencer.sv
// risc_sequencer: 8-phase CPU control sequencer with memory stall timeout, HALT/ERR states and illegal-opcode trap.
// Define RISC_SEQ_STEP_EN to add a single-instruction step input used while en=0.
module risc_sequencer #(
  parameter int OPC_W   = 3,
  parameter int TO_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_rdy,
`ifdef RISC_SEQ_STEP_EN
  input  logic             step,
`endif
  output logic [2:0]       phase,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             halt,
  output logic             inc_pc,
  output logic             ld_ac,
  output logic             wr,
  output logic             ld_pc,
  output logic             data_e,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal
);
  typedef enum logic [1:0] {RUN, HALT, ERR} state_t;
  localparam logic [TO_W-1:0] TO = TO_W'(TIMEOUT);
  state_t          r_state, w_state_n;
  logic [2:0]      r_phase, w_phase_n;
  logic [TO_W-1:0] r_cnt, w_cnt_n;
  logic            r_illegal, w_illegal_n;
  logic [2:0]      w_op;
  logic            w_bad, w_hlt, w_skz, w_sto, w_jmp, w_alu;
  logic            w_run, w_act, w_stall, w_stop, w_adv;
  assign w_op  = opcode[2:0];
  assign w_bad = |(opcode >> 3);
  assign w_hlt = w_op == 3'd0;
  assign w_skz = w_op == 3'd1;
  assign w_sto = w_op == 3'd6;
  assign w_jmp = w_op == 3'd7;
  assign w_alu = w_op >= 3'd2 && w_op <= 3'd5;
  assign w_run = r_state == RUN;
  assign w_stall = (r_phase == 3'd1 || (r_phase == 3'd5 && w_alu)) && !mem_rdy;
  assign w_stop  = r_phase == 3'd4 && (w_hlt || w_bad);
  assign w_adv   = w_run && w_act && !w_stop && !w_stall;
`ifdef RISC_SEQ_STEP_EN
  logic r_step, w_step_n;
  assign w_act    = en || r_step;
  // a step request latches here and is released when the instruction wraps back to phase 0
  assign w_step_n = r_step ? !(w_adv && r_phase == 3'd7) : (w_run && !en && step);
  always_ff @(posedge clk)
    r_step <= rst ? 1'b0 : w_step_n;
`else
  assign w_act = en;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_phase   <= 3'd0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_phase   <= w_phase_n;
      r_cnt     <= w_cnt_n;
      r_illegal <= w_illegal_n;
    end
  end
  always_comb begin
    w_state_n   = r_state;
    w_phase_n   = r_phase;
    w_cnt_n     = r_cnt;
    w_illegal_n = r_illegal;
    if (w_run && w_act) begin
      if (w_stop) begin
        w_state_n   = HALT;
        w_illegal_n = r_illegal || w_bad;
      end else if (w_stall) begin
        w_cnt_n   = r_cnt + 1'b1;
        w_state_n = (r_cnt + 1'b1 == TO) ? ERR : RUN;
      end else begin
        w_phase_n = r_phase + 3'd1;
        w_cnt_n   = '0;
      end
    end
    sel    = w_run && r_phase <= 3'd3;
    rd     = w_run && ((r_phase >= 3'd1 && r_phase <= 3'd3) || (r_phase >= 3'd5 && w_alu));
    ld_ir  = w_run && w_act && (r_phase == 3'd2 || r_phase == 3'd3);
    halt   = r_state == HALT || (w_run && r_phase == 3'd4 && w_hlt);
    inc_pc = w_run && w_act && (r_phase == 3'd4 || (r_phase == 3'd6 && w_skz && zero));
    ld_ac  = w_run && w_act && r_phase == 3'd7 && w_alu;
    ld_pc  = w_run && w_act && r_phase >= 3'd6 && w_jmp;
    wr     = w_run && w_act && r_phase == 3'd7 && w_sto;
    data_e = w_run && r_phase >= 3'd6 && w_sto;
  end
  assign phase   = r_phase;
  assign halted  = r_state == HALT;
  assign bus_err = r_state == ERR;
  assign illegal = r_illegal;
endmodule

// File: tb/tb_risc_sequencer.sv
// tb_risc_sequencer: directed vector table plus hand sequences for stall, timeout, halt, illegal and pause.
module tb_risc_sequencer;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, zero = 1'b0, mem_rdy = 1'b1;
  logic [4:0] opcode = 5'd0;
  logic [2:0] phase;
  logic sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e, halted, bus_err, illegal;
`ifdef RISC_SEQ_STEP_EN
  logic step = 1'b0;
`endif
  int total = 0, bad = 0;

  risc_sequencer #(.OPC_W(5), .TO_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .zero(zero), .mem_rdy(mem_rdy),
`ifdef RISC_SEQ_STEP_EN
    .step(step),
`endif
    .phase(phase), .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
    .ld_ac(ld_ac), .wr(wr), .ld_pc(ld_pc), .data_e(data_e),
    .halted(halted), .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // strobe order: sel rd ld_ir halt inc_pc ld_ac wr ld_pc data_e
  wire [8:0] s = {sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e};
  wire [2:0] f = {halted, bus_err, illegal};

  typedef struct {
    string      nm;
    logic [4:0] op;
    logic       z;
    logic [8:0] e5, e6, e7;
  } vec_t;
  vec_t vecs[8];
  logic [8:0] front[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    front = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000, 9'b000010000};
    vecs[0] = '{"ADD",   5'd2, 1'b0, 9'b010000000, 9'b010000000, 9'b010001000};
    vecs[1] = '{"AND",   5'd3, 1'b0, 9'b010000000, 9'b010000000, 9'b010001000};
    vecs[2] = '{"XOR",   5'd4, 1'b1, 9'b010000000, 9'b010000000, 9'b010001000};
    vecs[3] = '{"LDA",   5'd5, 1'b0, 9'b010000000, 9'b010000000, 9'b010001000};
    vecs[4] = '{"SKZ_z1", 5'd1, 1'b1, 9'b000000000, 9'b000010000, 9'b000000000};
    vecs[5] = '{"SKZ_z0", 5'd1, 1'b0, 9'b000000000, 9'b000000000, 9'b000000000};
    vecs[6] = '{"STO",   5'd6, 1'b0, 9'b000000000, 9'b000000001, 9'b000000101};
    vecs[7] = '{"JMP",   5'd7, 1'b1, 9'b000000000, 9'b000000010, 9'b000000010};

    do_reset();
    chk("rst_phase", 32'(phase), 0);
    chk("rst_strobes", 32'(s), 32'b100000000);
    chk("rst_flags", 32'(f), 0);

    en = 1'b1;
    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      zero = vecs[i].z;
      mem_rdy = 1'b1;
      do_reset();
      for (int p = 0; p < 8; p++) begin
        chk({vecs[i].nm, "_phase"}, 32'(phase), 32'(p));
        chk({vecs[i].nm, "_strobes"}, 32'(s),
            32'(p < 5 ? front[p] : p == 5 ? vecs[i].e5 : p == 6 ? vecs[i].e6 : vecs[i].e7));
        chk({vecs[i].nm, "_flags"}, 32'(f), 0);
        tick();
      end
      chk({vecs[i].nm, "_wrap"}, 32'(phase), 0);
    end

    opcode = 5'd2;
    do_reset();
    tick();
    mem_rdy = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_hold", 32'(phase), 1);
      chk("stall_no_err", 32'(bus_err), 0);
    end
    en = 1'b0;
    mem_rdy = 1'b1;
    tick();
    chk("en0_rdy1_hold", 32'(phase), 1);
    en = 1'b1;
    tick();
    chk("stall_release", 32'(phase), 2);

    do_reset();
    tick();
    mem_rdy = 1'b0;
    repeat (14) tick();
    chk("timeout_14", 32'(bus_err), 0);
    tick();
    chk("timeout_15", 32'(bus_err), 1);
    chk("err_strobes", 32'(s), 0);
    chk("err_phase", 32'(phase), 1);
    mem_rdy = 1'b1;
    tick();
    chk("err_sticky", 32'(f), 3'b010);
    do_reset();
    chk("err_rst_phase", 32'(phase), 0);
    chk("err_rst_flags", 32'(f), 0);

    opcode = 5'd0;
    do_reset();
    repeat (4) tick();
    chk("hlt_p4_strobes", 32'(s), 32'b000110000);
    chk("hlt_p4_flags", 32'(f), 0);
    tick();
    chk("hlt_halted", 32'(f), 3'b100);
    chk("hlt_strobes", 32'(s), 32'b000100000);
    tick();
    chk("hlt_phase", 32'(phase), 4);

    opcode = 5'b01010;
    do_reset();
    chk("ill_rst_flags", 32'(f), 0);
    repeat (4) tick();
    chk("ill_p4_strobes", 32'(s), 32'b000010000);
    tick();
    chk("ill_flags", 32'(f), 3'b101);
    chk("ill_phase", 32'(phase), 4);
    opcode = 5'd2;
    tick();
    chk("ill_sticky", 32'(illegal), 1);
    do_reset();
    chk("ill_rst", 32'(f), 0);

    opcode = 5'd6;
    do_reset();
    repeat (7) tick();
    chk("sto_p7", 32'(s), 32'b000000101);
    en = 1'b0;
    #1;
    chk("sto_pause_strobes", 32'(s), 32'b000000001);
    repeat (2) tick();
    chk("sto_pause_phase", 32'(phase), 7);
    chk("sto_pause_wr", 32'(wr), 0);
    en = 1'b1;
    #1;
    chk("sto_resume_wr", 32'(wr), 1);
    tick();
    chk("sto_resume_phase", 32'(phase), 0);

`ifdef RISC_SEQ_STEP_EN
    opcode = 5'd2;
    en = 1'b0;
    do_reset();
    repeat (2) tick();
    chk("step_idle", 32'(phase), 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (3) tick();
    chk("step_mid_phase", 32'(phase), 3);
    chk("step_ld_ir", 32'(ld_ir), 1);
    repeat (5) tick();
    chk("step_wrap", 32'(phase), 0);
    repeat (3) tick();
    chk("step_pause", 32'(phase), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
